// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared type definitions for the systolic array: the array controller's
// state encoding and the result drain engine's state encoding.
// No ports; import with "import systolic_pkg::*;".
// -----------------------------------------------------------------------------
package systolic_pkg;

   // Array controller phases (load operands, compute, hand results to drain).
   typedef enum logic [1:0] {
      CTRL_IDLE    = 2'd0,
      CTRL_LOAD    = 2'd1,
      CTRL_COMPUTE = 2'd2,
      CTRL_OUT     = 2'd3
   } ctrl_state_e;

   // Result drain engine phases.
   typedef enum logic [1:0] {
      DRN_IDLE  = 2'd0,
      DRN_DRAIN = 2'd1,
      DRN_CLEAR = 2'd2,
      DRN_DONE  = 2'd3
   } drain_state_e;

endpackage

// File: rtl/systolic_drain.sv
// -----------------------------------------------------------------------------
// systolic_drain
// Snapshots all SIZE x SIZE PE accumulators when the array controller enters
// its OUT phase, streams them out one word per transfer in row-major order,
// pulses an accumulator clear to the PEs, then reports done.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous, active-high reset
//   start      level: array controller is in its OUT phase
//   pe_acc     PE accumulators, PE(r,c) at slice r*SIZE+c (DATA_W each)
//   pe_clr     one-cycle accumulator clear pulse to the PEs
//   send_msg   result word (0 when send_val is low)
//   send_val   result valid
//   send_rdy   downstream ready
//   send_last  final word of the matrix
//   done       drain and clear complete
//   dbg_state  current drain state, for observation only
//
// Handshake: a word transfers on any cycle where send_val and send_rdy are
// both high. Once send_val is raised it stays high, and send_msg/send_last
// stay unchanged, until that transfer happens; send_rdy may change freely.
// -----------------------------------------------------------------------------
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int SIZE   = 4,
   parameter int DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [SIZE*SIZE*DATA_W-1:0]   pe_acc,
   output logic                          pe_clr,
   output logic [DATA_W-1:0]             send_msg,
   output logic                          send_val,
   input  logic                          send_rdy,
   output logic                          send_last,
   output logic                          done,
   output drain_state_e                  dbg_state
);

   localparam int                NUM      = SIZE * SIZE;
   localparam int                IDX_W    = $clog2(NUM);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM - 1);

   drain_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shadow_q [NUM];
   logic [DATA_W-1:0] shadow_d [NUM];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      send_val  = 1'b0;
      send_msg  = '0;
      send_last = 1'b0;
      pe_clr    = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         DRN_IDLE: begin
            if (start) begin
               state_d = DRN_DRAIN;
               idx_d   = '0;
               // Snapshot so later accumulator activity cannot leak into
               // the words still waiting to be sent.
               for (int i = 0; i < NUM; i++) begin
                  shadow_d[i] = pe_acc[i*DATA_W +: DATA_W];
               end
            end
         end

         DRN_DRAIN: begin
            send_val  = 1'b1;
            send_msg  = shadow_q[idx_q];
            send_last = (idx_q == IDX_LAST);
            if (send_rdy) begin
               // idx parks on the last entry rather than wrapping.
               if (idx_q == IDX_LAST) begin
                  state_d = DRN_CLEAR;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         DRN_CLEAR: begin
            pe_clr  = 1'b1;
            state_d = DRN_DONE;
         end

         DRN_DONE: begin
            done = 1'b1;
            // Wait for the controller to leave OUT so one start level
            // cannot trigger a second drain of the same results.
            if (!start) begin
               state_d = DRN_IDLE;
            end
         end

         default: begin
            state_d = DRN_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DRN_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Data-only storage: contents are meaningless until the next capture.
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_drain
// Self-checking bench for systolic_drain with SIZE=2, DATA_W=8.
// -----------------------------------------------------------------------------
module tb_systolic_drain;
   import systolic_pkg::*;

   localparam int SIZE   = 2;
   localparam int DATA_W = 8;
   localparam int NUM    = SIZE * SIZE;
   localparam int TW     = NUM * DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start    = 1'b0;
   logic              send_rdy = 1'b0;
   logic [TW-1:0]     pe_acc   = '0;
   logic              pe_clr;
   logic              send_val;
   logic              send_last;
   logic              done;
   logic [DATA_W-1:0] send_msg;
   drain_state_e      dbg_state;

   systolic_drain #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pe_acc    (pe_acc),
      .pe_clr    (pe_clr),
      .send_msg  (send_msg),
      .send_val  (send_val),
      .send_rdy  (send_rdy),
      .send_last (send_last),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   int clr_cnt   = 0;
   int last_cnt  = 0;
   int stall_cnt = 0;
   logic              hold_pending = 1'b0;
   logic [DATA_W-1:0] hold_msg     = '0;
   logic              hold_last    = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_w;
      if (pe_clr) clr_cnt++;
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (!send_val) begin
            check("msg_zero_when_invalid", 32'(send_msg), 32'h0);
            check("last_low_when_invalid", 32'(send_last), 32'h0);
         end
         if (hold_pending) begin
            check("hold_val", 32'(send_val), 32'h1);
            check("hold_msg", 32'(send_msg), 32'(hold_msg));
            check("hold_last", 32'(send_last), 32'(hold_last));
         end
         if (send_val && send_rdy) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 32'(send_val), 32'h0);
            end else begin
               exp_w = exp_q.pop_front();
               check("data", 32'(send_msg), 32'(exp_w));
               check("last_flag", 32'(send_last), 32'(exp_q.size() == 0));
               if (send_last) last_cnt++;
            end
         end
         if (send_val && !send_rdy) stall_cnt++;
         hold_pending = send_val && !send_rdy;
         hold_msg     = send_msg;
         hold_last    = send_last;
      end
   end

   // ---------------- driver tasks ----------------
   // mode 0: ready always high; mode 1: ready low for 3 cycles while the
   // second word is offered; mode 2: random ready, random start toggles while
   // draining, random accumulator churn after capture.
   task automatic run_matrix(input logic [TW-1:0] words, input int mode,
                             input bit snap, input int hold_cycles);
      int cyc = 0;
      bit seen = 1'b0;
      clr_cnt   = 0;
      last_cnt  = 0;
      stall_cnt = 0;
      for (int i = 0; i < NUM; i++) exp_q.push_back(words[i*DATA_W +: DATA_W]);
      pe_acc   = words;
      start    = 1'b1;
      send_rdy = 1'b1;
      while (!seen && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (snap && cyc == 1) pe_acc = '1;
         case (mode)
            1: send_rdy = !(cyc >= 2 && cyc <= 4);
            2: begin
               send_rdy = ($urandom_range(0, 3) != 0);
               for (int i = 0; i < NUM; i++) pe_acc[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            default: send_rdy = 1'b1;
         endcase
         if (mode == 2 && cyc < NUM) start = 1'($urandom_range(0, 1));
         else start = 1'b1;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_reached", 32'(seen), 32'h1);
      if (mode == 0) check("drain_latency", 32'(cyc), 32'(NUM + 2));
      if (mode == 1) begin
         check("drain_latency_bp", 32'(cyc), 32'(NUM + 2 + 3));
         check("stall_count", 32'(stall_cnt), 32'h3);
      end
      check("words_left", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      check("last_count", 32'(last_cnt), 32'h1);
      check("clr_count", 32'(clr_cnt), 32'h1);
      for (int h = 0; h < hold_cycles; h++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("done_held", 32'(done), 32'h1);
         check("no_val_in_done", 32'(send_val), 32'h0);
      end
      check("clr_count_after_hold", 32'(clr_cnt), 32'h1);
      start = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("done_cleared", 32'(done), 32'h0);
   endtask

   task automatic reset_mid_drain();
      clr_cnt = 0;
      for (int i = 0; i < NUM; i++) exp_q.push_back(DATA_W'(8'h11 * (i + 1)));
      pe_acc   = 32'h44332211;
      start    = 1'b1;
      send_rdy = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) begin
            rst      = 1'b1;
            send_rdy = 1'b0;
         end
         @(negedge clk);
      end
      check("words_before_reset", 32'(exp_q.size()), 32'h2);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_val", 32'(send_val), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_last", 32'(send_last), 32'h0);
      check("rst_msg", 32'(send_msg), 32'h0);
      exp_q.delete();
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_overrides_start", 32'(send_val), 32'h0);
      check("clr_after_reset", 32'(clr_cnt), 32'h0);
      rst = 1'b0;
      run_matrix(32'h88776655, 0, 1'b0, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [TW-1:0] w;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_val", 32'(send_val), 32'h0);
      check("reset_last", 32'(send_last), 32'h0);
      check("reset_msg", 32'(send_msg), 32'h0);
      check("reset_clr", 32'(pe_clr), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_state", 32'(dbg_state), 32'(DRN_IDLE));
      rst = 1'b0;

      run_matrix(32'h04030201, 0, 1'b0, 0);   // basic
      run_matrix(32'h04030201, 1, 1'b0, 0);   // backpressure at second word
      run_matrix(32'h04030201, 0, 1'b1, 4);   // snapshot, then start held in DONE
      run_matrix(32'h0D0C0B0A, 0, 1'b0, 0);   // restart with new data
      reset_mid_drain();

      for (int m = 0; m < 100; m++) begin
         for (int i = 0; i < NUM; i++) w[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         run_matrix(w, 2, 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
